// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
// Imported by hazard_ctrl and load_use_detect.
package hazard_pkg;

    localparam int unsigned REGADDRESS_W_DEFAULT = 5;
    localparam int unsigned MDU_TIMEOUT_DEFAULT  = 64;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Flags a load in EX whose destination feeds a live source operand of the ID instruction.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int unsigned regAddress_w = REGADDRESS_W_DEFAULT
) (
    input  logic                    ex_memread,
    input  logic [regAddress_w-1:0] ex_rd,
    input  logic [regAddress_w-1:0] id_rs1,
    input  logic [regAddress_w-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    output logic                    hazard
);

    logic rd_nonzero;
    logic hit_rs1;
    logic hit_rs2;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rd_nonzero = (ex_rd != '0);
    assign hit_rs1    = id_use_rs1 && (ex_rd == id_rs1);
    assign hit_rs2    = id_use_rs2 && (ex_rd == id_rs2);
    assign hazard     = ex_memread && rd_nonzero && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle unit stall
// with timeout abort, plus a saturating stall-cycle counter and sticky error flag.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned regAddress_w = REGADDRESS_W_DEFAULT,
    parameter int unsigned MDU_TIMEOUT  = MDU_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [regAddress_w-1:0] id_rs1,
    input  logic [regAddress_w-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic                    ex_memread,
    input  logic [regAddress_w-1:0] ex_rd,
    input  logic                    ex_branch_taken,
    input  logic                    ex_mdu_start,
    input  logic                    mdu_done,
    output logic                    pc_en,
    output logic                    ifid_en,
    output logic                    idex_en,
    output logic                    ifid_flush,
    output logic                    idex_flush,
    output logic                    exmem_bubble,
    output logic                    mdu_abort,
    output logic                    err_sticky,
    output logic [15:0]             stall_cnt
);

    localparam int unsigned BUSY_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(MDU_TIMEOUT);

    hazard_state_t     state;
    hazard_state_t     state_next;
    logic [BUSY_W-1:0] busy_cnt;
    logic [BUSY_W-1:0] busy_cnt_next;
    logic              load_use;

    load_use_detect #(
        .regAddress_w (regAddress_w)
    ) u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hazard     (load_use)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            busy_cnt   <= '0;
            err_sticky <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state    <= state_next;
            busy_cnt <= busy_cnt_next;
            if (mdu_abort) begin
                err_sticky <= 1'b1;
            end
            if (!pc_en && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        busy_cnt_next = busy_cnt;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_bubble  = 1'b0;
        mdu_abort     = 1'b0;

        unique case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mdu_start && !mdu_done) begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_bubble  = 1'b1;
                    state_next    = MDU_BUSY;
                    busy_cnt_next = BUSY_W'(1);
                end else if (load_use) begin
                    // ID/EX still written so the flushed NOP enters EX behind the load
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end

            MDU_BUSY: begin
                if (mdu_done) begin
                    state_next    = RUN;
                    busy_cnt_next = '0;
                end else if (busy_cnt == BUSY_LIMIT) begin
                    mdu_abort     = 1'b1;
                    idex_flush    = 1'b1;
                    state_next    = RUN;
                    busy_cnt_next = '0;
                end else begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_bubble  = 1'b1;
                    busy_cnt_next = busy_cnt + BUSY_W'(1);
                end
            end

            default: begin
                state_next    = RUN;
                busy_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_TIMEOUT reduced to 8).
// Control outputs are packed {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, mdu_abort}.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    localparam logic [6:0] C_RUN   = 7'b111_000_0;
    localparam logic [6:0] C_BR    = 7'b111_110_0;
    localparam logic [6:0] C_LU    = 7'b001_010_0;
    localparam logic [6:0] C_MDU   = 7'b000_001_0;
    localparam logic [6:0] C_ABORT = 7'b111_010_1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memread;
    logic          ex_branch_taken, ex_mdu_start, mdu_done;
    logic          pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble;
    logic          mdu_abort, err_sticky;
    logic [15:0]   stall_cnt;
    logic [6:0]    ctl;

    int checks = 0;
    int fails  = 0;

    hazard_ctrl #(
        .regAddress_w (AW),
        .MDU_TIMEOUT  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_start    (ex_mdu_start),
        .mdu_done        (mdu_done),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_bubble    (exmem_bubble),
        .mdu_abort       (mdu_abort),
        .err_sticky      (err_sticky),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_bubble, mdu_abort};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1          = '0;
        id_rs2          = '0;
        ex_rd           = '0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_memread      = 1'b0;
        ex_branch_taken = 1'b0;
        ex_mdu_start    = 1'b0;
        mdu_done        = 1'b0;
    endtask

    task automatic load_use_rs1(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic use1);
        idle();
        ex_memread = 1'b1;
        ex_rd      = rd;
        id_rs1     = rs1;
        id_use_rs1 = use1;
    endtask

    // Called 1ns after a rising edge: checks this cycle's outputs, then moves to the next cycle.
    task automatic cycle(input string tag, input logic [6:0] exp);
        #2 check(tag, {25'd0, ctl}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("reset_ctl", {25'd0, ctl}, {25'd0, C_RUN});
        check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset_err", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // load-use on rs1 and on rs2: one stall cycle each
        load_use_rs1(5'd5, 5'd5, 1'b1);
        cycle("lu_rs1", C_LU);
        idle();
        cycle("lu_rs1_release", C_RUN);
        check("lu_rs1_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle("lu_rs2", C_LU);

        // no hazard: rd==0, operand unused, register mismatch, rs2 match but unused
        load_use_rs1(5'd0, 5'd0, 1'b1);
        cycle("lu_rd_zero", C_RUN);
        load_use_rs1(5'd5, 5'd5, 1'b0);
        cycle("lu_rs1_unused", C_RUN);
        load_use_rs1(5'd5, 5'd6, 1'b1);
        cycle("lu_mismatch", C_RUN);
        idle();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b0;
        cycle("lu_rs2_unused", C_RUN);
        check("no_stall_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // branch beats a simultaneous load-use hazard
        load_use_rs1(5'd5, 5'd5, 1'b1);
        ex_branch_taken = 1'b1;
        cycle("branch_over_lu", C_BR);
        idle();
        cycle("branch_release", C_RUN);
        check("branch_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // MDU op finishing on the 4th cycle; a branch during busy is ignored
        idle();
        ex_mdu_start = 1'b1;
        cycle("mdu_start", C_MDU);
        idle();
        cycle("mdu_busy1", C_MDU);
        ex_branch_taken = 1'b1;
        cycle("mdu_busy_branch", C_MDU);
        idle();
        mdu_done = 1'b1;
        cycle("mdu_done", C_RUN);
        idle();
        cycle("mdu_after", C_RUN);
        check("mdu_stall_cnt", {16'd0, stall_cnt}, 32'd5);

        // start and done together: no stall
        ex_mdu_start = 1'b1;
        mdu_done     = 1'b1;
        cycle("mdu_instant", C_RUN);
        idle();
        cycle("mdu_instant_after", C_RUN);
        check("mdu_instant_stall_cnt", {16'd0, stall_cnt}, 32'd5);

        // timeout: 7 busy stall cycles after the start cycle, abort on the 8th busy cycle
        ex_mdu_start = 1'b1;
        cycle("to_start", C_MDU);
        idle();
        for (int i = 1; i <= 7; i++) begin
            cycle($sformatf("to_busy%0d", i), C_MDU);
        end
        check("to_err_before", {31'd0, err_sticky}, 32'd0);
        cycle("to_abort", C_ABORT);
        check("to_err_after", {31'd0, err_sticky}, 32'd1);
        cycle("to_run_next", C_RUN);
        check("to_stall_cnt", {16'd0, stall_cnt}, 32'd13);

        // done in the same cycle the timeout would fire: done wins
        ex_mdu_start = 1'b1;
        cycle("tie_start", C_MDU);
        idle();
        for (int i = 1; i <= 7; i++) begin
            cycle($sformatf("tie_busy%0d", i), C_MDU);
        end
        mdu_done = 1'b1;
        cycle("tie_done_wins", C_RUN);
        idle();
        check("tie_stall_cnt", {16'd0, stall_cnt}, 32'd21);
        check("tie_err_kept", {31'd0, err_sticky}, 32'd1);

        // reset asserted during the 2nd busy cycle
        ex_mdu_start = 1'b1;
        cycle("rst_start", C_MDU);
        idle();
        cycle("rst_busy1", C_MDU);
        rst = 1'b1;
        #1;
        check("rst_mid_ctl", {25'd0, ctl}, {25'd0, C_RUN});
        check("rst_mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_mid_err", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle("rst_run_idle", C_RUN);
        load_use_rs1(5'd4, 5'd4, 1'b1);
        cycle("rst_run_lu", C_LU);
        idle();
        cycle("rst_run_release", C_RUN);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
